// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window controller.
//   - default data/result widths
//   - controller state encoding
//   - window addressing and flattened-bus packing helpers
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 25;
  localparam int WIN_N      = 16;   // 4x4 window / kernel entries

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CALC,
    OUT,
    DONE
  } state_t;

  // Row-major pixel address of window element k (k = i*4+j) for the output
  // position (r,c).  Evaluated in 32 bits so it cannot wrap before truncation.
  function automatic int unsigned win_addr(int unsigned r, int unsigned c,
                                           int unsigned k, int unsigned img_w);
    return (r + k / 4) * img_w + c + (k % 4);
  endfunction

  // LSB of element k inside a flattened 16-entry bus of w-bit elements.
  function automatic int win_lsb(int k, int w);
    return k * w;
  endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// Result stream between the window controller (master) and the downstream
// sink (slave).  A result transfers on a clock edge where out_valid and
// out_ready are both high.
//   out_valid  master->slave  result available
//   out_ready  slave->master  sink accepts
//   out_data   master->slave  result value
//   out_row    master->slave  output row of out_data
//   out_col    master->slave  output column of out_data
interface conv_window_ctrl_if #(
  parameter int ACC_W = conv_pkg::ACC_W_DEF
);
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [7:0]       out_row;
  logic [7:0]       out_col;

  modport master (output out_valid, out_data, out_row, out_col, input out_ready);
  modport slave  (input out_valid, out_data, out_row, out_col, output out_ready);
endinterface

// File: rtl/conv_win_regs.sv
// 16-entry register file with one indexed write port and a flattened read bus.
// Used for both the pixel window and the kernel.
//   clk, rst_n  clock, async active-low reset (clears all entries)
//   wr_en       write strobe
//   wr_addr     entry index, row-major
//   wr_data     entry value
//   rd_bus      entry k at [k*DATA_W +: DATA_W]
module conv_win_regs
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [3:0]              wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [WIN_N*DATA_W-1:0] rd_bus
);

  logic [DATA_W-1:0] regs [WIN_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < WIN_N; g++) begin : g_pack
    assign rd_bus[win_lsb(g, DATA_W) +: DATA_W] = regs[g];
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencing controller for the 4x4 signed MAC convolution datapath.
// For every output position (row-major over an (IMG_H-3)x(IMG_W-3) grid) it
// reads the 16 window pixels from a single-port memory, lets the external
// combinational datapath compute over window x kernel, registers the result
// and offers it on a valid/ready stream.
//   clk, rst_n          clock, async active-low reset
//   start               begin a pass (IDLE only)
//   busy, done          status; done pulses once after the last transfer
//   k_wr_*              kernel write port (IDLE only)
//   mem_rd_*            feature-map read port, data returns one cycle later
//   dp_window/dp_kernel flattened operand buses to the datapath
//   dp_result           datapath result
//   out_if              result stream (master)
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    k_wr_en,
  input  logic [3:0]              k_wr_addr,
  input  logic [DATA_W-1:0]       k_wr_data,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic [WIN_N*DATA_W-1:0] dp_window,
  output logic [WIN_N*DATA_W-1:0] dp_kernel,
  input  logic [ACC_W-1:0]        dp_result,
  conv_window_ctrl_if.master      out_if
);

  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 4);
  localparam logic [7:0] LAST_COL = 8'(IMG_W - 4);

  state_t     state;
  logic [3:0] fidx;        // window element whose address is on mem_rd_addr
  logic [7:0] row, col;    // current output position

  function automatic logic [ADDR_W-1:0] addr_of(logic [7:0] r, logic [7:0] c,
                                                int unsigned k);
    return ADDR_W'(win_addr(32'(r), 32'(c), k, IMG_W));
  endfunction

  // Next position in row-major order
  logic       last_pos;
  logic [7:0] nrow, ncol;
  assign last_pos = (row == LAST_ROW) && (col == LAST_COL);
  assign ncol     = (col == LAST_COL) ? 8'd0 : col + 8'd1;
  assign nrow     = (col == LAST_COL) ? row + 8'd1 : row;

  // Read data lags the address by one cycle: while element fidx is being
  // addressed, element fidx-1 is on mem_rd_data.  The last element lands
  // during WAIT.
  logic       win_we;
  logic [3:0] win_wa;
  assign win_we = ((state == FETCH) && (fidx != 4'd0)) || (state == WAIT);
  assign win_wa = (state == WAIT) ? 4'd15 : fidx - 4'd1;

  logic ker_we;
  assign ker_we = k_wr_en && (state == IDLE);

  conv_win_regs #(.DATA_W(DATA_W)) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (win_we),
    .wr_addr (win_wa),
    .wr_data (mem_rd_data),
    .rd_bus  (dp_window)
  );

  conv_win_regs #(.DATA_W(DATA_W)) u_ker (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ker_we),
    .wr_addr (k_wr_addr),
    .wr_data (k_wr_data),
    .rd_bus  (dp_kernel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_rd_en        <= 1'b0;
      mem_rd_addr      <= '0;
      fidx             <= '0;
      row              <= '0;
      col              <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_row   <= '0;
      out_if.out_col   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= FETCH;
          busy        <= 1'b1;
          row         <= '0;
          col         <= '0;
          fidx        <= '0;
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= addr_of(8'd0, 8'd0, 0);
        end
        FETCH: begin
          if (fidx == 4'd15) begin
            state     <= WAIT;
            mem_rd_en <= 1'b0;
          end else begin
            fidx        <= fidx + 4'd1;
            mem_rd_addr <= addr_of(row, col, 32'(fidx) + 32'd1);
          end
        end
        WAIT: state <= CALC;
        CALC: begin
          out_if.out_data  <= dp_result;
          out_if.out_row   <= row;
          out_if.out_col   <= col;
          out_if.out_valid <= 1'b1;
          state            <= OUT;
        end
        OUT: if (out_if.out_ready) begin
          out_if.out_valid <= 1'b0;
          if (last_pos) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= FETCH;
            row         <= nrow;
            col         <= ncol;
            fidx        <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= addr_of(nrow, ncol, 0);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;

  localparam int DW = 8, AW = 25, IW = 8, IH = 8, ADW = 6;
  localparam int OW = IW - 3, OH = IH - 3;

  logic           clk = 1'b0;
  logic           rst_n, start, k_wr_en;
  logic [3:0]     k_wr_addr;
  logic [DW-1:0]  k_wr_data;
  logic           busy, done, mem_rd_en;
  logic [ADW-1:0] mem_rd_addr;
  logic [DW-1:0]  mem_rd_data;
  logic [16*DW-1:0] dp_window, dp_kernel;
  logic [AW-1:0]  dp_result;

  conv_window_ctrl_if #(.ACC_W(AW)) oif ();

  always #5 clk = ~clk;

  conv_window_ctrl #(.DATA_W(DW), .ACC_W(AW), .IMG_W(IW), .IMG_H(IH), .ADDR_W(ADW)) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .busy (busy), .done (done),
    .k_wr_en (k_wr_en), .k_wr_addr (k_wr_addr), .k_wr_data (k_wr_data),
    .mem_rd_en (mem_rd_en), .mem_rd_addr (mem_rd_addr), .mem_rd_data (mem_rd_data),
    .dp_window (dp_window), .dp_kernel (dp_kernel), .dp_result (dp_result),
    .out_if (oif)
  );

  // Feature-map memory: one-cycle read latency
  logic signed [7:0] mem  [IW*IH];
  logic signed [7:0] kern [16];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  // Stand-in for the external combinational MAC datapath
  always_comb begin
    int acc, a, b;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      a = $signed(dp_window[k*DW +: DW]);
      b = $signed(dp_kernel[k*DW +: DW]);
      acc = acc + a * b;
    end
    dp_result = acc[AW-1:0];
  end

  // Reference: expected results in visiting order, straight from the image
  typedef struct {int r; int c; longint v;} res_t;
  res_t   exp_q[$];
  longint got [OH][OW];
  int     pass_cnt = 0, tot_cnt = 0, n_xfer = 0;
  logic   exp_done = 1'b0;

  task automatic chk(string nm, longint act, longint expv);
    tot_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
  endtask

  function automatic longint ref_val(int r, int c);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        s += longint'(mem[(r+i)*IW + c + j]) * longint'(kern[i*4+j]);
    return s;
  endfunction

  task automatic build_expect();
    res_t e;
    exp_q.delete();
    n_xfer = 0;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        e.r = r; e.c = c; e.v = ref_val(r, c);
        exp_q.push_back(e);
        got[r][c] = -1;
      end
  endtask

  // Compare process: stream contents, done timing, no reads while presenting
  always @(negedge clk) begin
    if (rst_n) begin
      chk("done_pulse", longint'(done), longint'(exp_done));
      exp_done = 1'b0;
      if (oif.out_valid) begin
        chk("no_read_while_valid", longint'(mem_rd_en), 0);
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          chk("out_data", longint'($signed(oif.out_data)), exp_q[0].v);
          chk("out_row", longint'(oif.out_row), longint'(exp_q[0].r));
          chk("out_col", longint'(oif.out_col), longint'(exp_q[0].c));
          if (oif.out_ready) begin
            got[exp_q[0].r][exp_q[0].c] = longint'($signed(oif.out_data));
            n_xfer++;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
      end
    end else begin
      exp_done = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_rd_en"}, longint'(mem_rd_en), 0);
    chk({tag, "_rd_addr"}, longint'(mem_rd_addr), 0);
    chk({tag, "_valid"}, longint'(oif.out_valid), 0);
    chk({tag, "_data"}, longint'(oif.out_data), 0);
    chk({tag, "_row"}, longint'(oif.out_row), 0);
    chk({tag, "_col"}, longint'(oif.out_col), 0);
    chk({tag, "_window_zero"}, longint'(dp_window == '0), 1);
    chk({tag, "_kernel_zero"}, longint'(dp_kernel == '0), 1);
  endtask

  task automatic load_kernel(int v);
    for (int i = 0; i < 16; i++) begin
      k_wr_en = 1'b1; k_wr_addr = 4'(i); k_wr_data = 8'(v); kern[i] = 8'(v);
      cyc();
    end
    k_wr_en = 1'b0;
  endtask

  task automatic wait_done(int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin cyc(); n++; end
    chk("done_seen", longint'(done === 1'b1), 1);
    cyc();
    chk("idle_after_done", longint'(busy), 0);
  endtask

  task automatic run_pass();
    start = 1'b1; cyc(); start = 1'b0;
    wait_done(2000);
    chk("xfer_count", n_xfer, OW*OH);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
    oif.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) kern[i] = '0;
    for (int a = 0; a < IW*IH; a++) mem[a] = 8'(a);
    #12;
    check_zero("reset");
    cyc(); rst_n = 1'b1; cyc();

    // Pass 1: kernel +1, mem[a]=a, timing, stall, ignored busy write
    load_kernel(1);
    build_expect();
    chk("model_00", exp_q[0].v, 216);
    chk("model_01", exp_q[1].v, 232);
    chk("model_44", exp_q[24].v, 792);
    start = 1'b1; cyc(); start = 1'b0;         // edge N sampled start
    for (int i = 0; i < 16; i++) begin
      chk("fetch_en", longint'(mem_rd_en), 1);
      chk("fetch_addr", longint'(mem_rd_addr), longint'((i/4)*IW + i%4));
      chk("fetch_busy", longint'(busy), 1);
      if (i == 3) begin k_wr_en = 1'b1; k_wr_addr = 4'd0; k_wr_data = 8'd5; end
      if (i == 4) k_wr_en = 1'b0;
      cyc();
    end
    chk("fetch_end_en", longint'(mem_rd_en), 0);
    chk("valid_early_16", longint'(oif.out_valid), 0);
    cyc();
    chk("valid_early_17", longint'(oif.out_valid), 0);
    cyc();
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", longint'(oif.out_valid), 1);
      chk("stall_data", longint'(oif.out_data), 216);
      chk("stall_rd_en", longint'(mem_rd_en), 0);
      cyc();
    end
    oif.out_ready = 1'b1;
    cyc();
    chk("first_xfer", longint'(oif.out_valid), 0);
    chk("first_xfer_count", n_xfer, 1);
    wait_done(2000);
    chk("xfer_count", n_xfer, OW*OH);
    chk("got_00", got[0][0], 216);
    chk("got_01", got[0][1], 232);
    chk("got_44", got[4][4], 792);
    chk("kernel_write_ignored", longint'(dp_kernel[7:0]), 1);

    // Pass 2: same memory and kernel, identical results
    build_expect();
    run_pass();
    chk("pass2_got_44", got[4][4], 792);
    chk("pass2_got_23", got[2][3], 216 + 16*(2*IW+3));

    // Pass 3: kernel -1, every pixel -128
    load_kernel(-1);
    for (int a = 0; a < IW*IH; a++) mem[a] = 8'sh80;
    build_expect();
    chk("model_neg", exp_q[7].v, 2048);
    run_pass();
    chk("neg_got_00", got[0][0], 2048);
    chk("neg_got_44", got[4][4], 2048);

    // Reset mid-FETCH
    load_kernel(1);
    build_expect();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("pre_reset_fetching", longint'(mem_rd_en), 1);
    #1 rst_n = 1'b0;
    #1 check_zero("midreset");
    exp_q.delete();
    cyc(); rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      chk("post_reset_idle", longint'(busy | mem_rd_en | oif.out_valid | done), 0);
      cyc();
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencing controller for the team's combinational 4x4 signed multiply-accumulate convolution datapath.
- Holds a 4x4 kernel register set and fetches each 4x4 input window from a single-read-port feature-map memory.
- Presents window and kernel to the datapath as flattened buses, registers the datapath result, and emits one result per output position over a valid/ready stream.
- Sits between the feature-map RAM and the downstream result sink/accumulator. Stride 1, no padding.

Parameters:
- DATA_W, 8, signed pixel/kernel width.
- ACC_W, 25, result width; matches the datapath output.
- IMG_W, 8, feature-map width in pixels (>=4).
- IMG_H, 8, feature-map height in pixels (>=4).
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a full-image pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result transfers.
- k_wr_en  in  1  kernel write strobe; honoured only in IDLE.
- k_wr_addr  in  4  kernel index, row-major (i*4+j).
- k_wr_data  in  DATA_W  kernel coefficient.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  pixel address, row-major (y*IMG_W+x).
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- dp_window  out  16*DATA_W  window bus; element k occupies bits [k*DATA_W +: DATA_W].
- dp_kernel  out  16*DATA_W  kernel bus; same packing as dp_window.
- dp_result  in  ACC_W  combinational datapath result.
- out_valid  out  1  result available.
- out_ready  in  1  sink accepts the result.
- out_data  out  ACC_W  registered result.
- out_row  out  8  output row index of out_data.
- out_col  out  8  output column index of out_data.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, mem_rd_en, out_valid = 0; mem_rd_addr, out_data, out_row, out_col = 0; window and kernel registers = 0.
- Output grid: OUT_W = IMG_W-3, OUT_H = IMG_H-3. Positions are visited row-major, (0,0) first, (OUT_H-1,OUT_W-1) last.
- FSM states:
  - IDLE -> FETCH on start=1. Position counters clear to 0.
  - FETCH: lasts 16 cycles, k=0..15. mem_rd_en=1 and mem_rd_addr=(row+k/4)*IMG_W+(col+k%4). mem_rd_data is captured into win[k-1] for k>=1. -> WAIT after k=15.
  - WAIT: captures win[15]; mem_rd_en=0. -> CALC.
  - CALC: out_data<=dp_result; out_row/out_col<=row/col. -> OUT.
  - OUT: out_valid=1; out_data, out_row and out_col held stable until out_valid&&out_ready at an edge. On transfer: if this is the last position -> DONE; otherwise advance col (wrapping to 0 with row+1 at OUT_W) -> FETCH.
  - DONE: done=1 for one cycle. -> IDLE.
- Latency: out_valid rises 18 edges after the edge that samples start. Each further result follows 18 edges after the previous transfer.
- dp_kernel is driven continuously from the kernel registers. dp_window is driven continuously from the window registers; it is stable and complete during CALC.
- Kernel writes and start pulses outside IDLE are ignored. A kernel write and start in the same IDLE cycle: the write is committed and the pass starts.
- out_ready is ignored when out_valid=0. No combinational path from out_ready to any output.
- Reset mid-pass: immediate return to reset values. No done pulse. The kernel must be reloaded.
- All arithmetic is signed two's complement and performed by the datapath. The controller does no arithmetic on data, only address computation, which is unsigned and must not wrap for legal parameters.

Decomposition:
- Shared package conv_pkg: DATA_W/ACC_W defaults, state enum (IDLE, FETCH, WAIT, CALC, OUT, DONE), and the window packing macro/function.
- One sub-module, conv_win_regs: 16-entry DATA_W register array with an indexed write port and a flattened read bus, instantiated twice (window and kernel).
- Datapath instantiation stays outside this block.

Test Plan:
- Reset mid-FETCH (rst_n low for 1 cycle at cycle 7) -> all outputs 0 and state IDLE in the same cycle; no done pulse.
- Kernel all +1; memory[a]=a; start -> first result (0,0)=216, (0,1)=232, (4,4)=792; exactly 25 transfers; done one cycle after the last transfer.
- Kernel all -1; memory all -128 (0x80) -> every result +2048; confirms signed capture and packing.
- out_ready held low 5 cycles at the first result -> out_valid stays 1, out_data=216 stable, no mem_rd_en; the transfer happens on the first ready cycle.
- k_wr_en (addr 0, data 5) while busy -> ignored; after done, a second pass with the same memory gives identical results.
- Timing check: start sampled at edge N -> mem_rd_en high for edges N+1..N+16, first mem_rd_addr=0, 16th=27, out_valid high after edge N+18.
